// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : game_controller
//  Description : Two-player tic-tac-toe referee. Alternates turns between
//                player 1 and player 2 with a valid/ready handshake, rejects
//                illegal moves, detects wins/draws, and optionally forfeits a
//                player who holds the turn too long.
//  Ports       : clk, rst_n (async active-low)
//                start                      - begin a new game (IDLE/DONE)
//                p1_valid/p1_row/p1_col     - player 1 move
//                p2_valid/p2_row/p2_col     - player 2 move
//                p1_ready/p2_ready          - move accepted this cycle
//                board[17:0]                - 2 bits per cell, cell=row*3+col
//                turn, move_count           - whose move, moves accepted
//                move_invalid               - one-cycle reject pulse
//                game_over, winner, timed_out - result while in DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module game_controller #(
    parameter int TURN_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        p1_valid,
    input  logic [1:0]  p1_row,
    input  logic [1:0]  p1_col,
    input  logic        p2_valid,
    input  logic [1:0]  p2_row,
    input  logic [1:0]  p2_col,
    output logic        p1_ready,
    output logic        p2_ready,
    output logic [17:0] board,
    output logic        turn,
    output logic [3:0]  move_count,
    output logic        move_invalid,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        timed_out
);

    // Timer only needs to count up to TURN_TIMEOUT; a width of 1 keeps the
    // vector legal when the timeout is disabled.
    localparam int c_TW = (TURN_TIMEOUT < 2) ? 1 : $clog2(TURN_TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'((TURN_TIMEOUT == 0) ? 0 : TURN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_P1 = 3'd1,
        S_WAIT_P2 = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state;
    logic [17:0]     r_board;
    logic            r_turn;
    logic [3:0]      r_move_count;
    logic            r_move_invalid;
    logic [1:0]      r_winner;
    logic            r_timed_out;
    logic [c_TW-1:0] r_timer;

    logic            w_hs;
    logic [1:0]      w_row;
    logic [1:0]      w_col;
    logic [3:0]      w_idx;
    logic            w_occupied;
    logic            w_legal;
    logic [1:0]      w_mover_code;
    logic [8:0]      w_own;
    logic            w_win;
    logic            w_timeout;

    // Only the player whose WAIT state is active can handshake; the other
    // player's valid is simply not looked at.
    assign w_hs  = ((r_state == S_WAIT_P1) && p1_valid) ||
                   ((r_state == S_WAIT_P2) && p2_valid);
    assign w_row = (r_state == S_WAIT_P2) ? p2_row : p1_row;
    assign w_col = (r_state == S_WAIT_P2) ? p2_col : p1_col;
    assign w_idx = ({2'b00, w_row} * 4'd3) + {2'b00, w_col};

    assign w_mover_code = r_turn ? 2'b10 : 2'b01;

    always_comb begin
        w_occupied = 1'b0;
        w_own      = '0;
        for (int i = 0; i < 9; i++) begin
            if ((w_idx == 4'(i)) && (r_board[2*i +: 2] != 2'b00))
                w_occupied = 1'b1;
            w_own[i] = (r_board[2*i +: 2] == w_mover_code);
        end
    end

    // Row/column value 3 is off-board; w_idx may alias a real cell then,
    // so the range test must gate the occupancy result.
    assign w_legal = w_hs && (w_row != 2'd3) && (w_col != 2'd3) && !w_occupied;

    assign w_win = (w_own[0] & w_own[1] & w_own[2]) |
                   (w_own[3] & w_own[4] & w_own[5]) |
                   (w_own[6] & w_own[7] & w_own[8]) |
                   (w_own[0] & w_own[3] & w_own[6]) |
                   (w_own[1] & w_own[4] & w_own[7]) |
                   (w_own[2] & w_own[5] & w_own[8]) |
                   (w_own[0] & w_own[4] & w_own[8]) |
                   (w_own[2] & w_own[4] & w_own[6]);

    // Fires on the edge where the timer would step onto TURN_TIMEOUT.
    assign w_timeout = (TURN_TIMEOUT != 0) && (r_timer == c_TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_board        <= '0;
            r_turn         <= 1'b0;
            r_move_count   <= '0;
            r_move_invalid <= 1'b0;
            r_winner       <= 2'b00;
            r_timed_out    <= 1'b0;
            r_timer        <= '0;
        end else begin
            r_move_invalid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_WAIT_P1;
                        r_board      <= '0;
                        r_turn       <= 1'b0;
                        r_move_count <= '0;
                        r_winner     <= 2'b00;
                        r_timed_out  <= 1'b0;
                        r_timer      <= '0;
                    end
                end
                S_WAIT_P1, S_WAIT_P2: begin
                    // A legal move wins over a timeout landing on the same edge.
                    if (w_legal) begin
                        for (int i = 0; i < 9; i++) begin
                            if (w_idx == 4'(i))
                                r_board[2*i +: 2] <= w_mover_code;
                        end
                        r_move_count <= r_move_count + 4'd1;
                        r_state      <= S_CHECK;
                    end else begin
                        if (w_hs)
                            r_move_invalid <= 1'b1;
                        if (w_timeout) begin
                            r_state     <= S_DONE;
                            r_winner    <= r_turn ? 2'b01 : 2'b10;
                            r_timed_out <= 1'b1;
                        end else if (TURN_TIMEOUT != 0) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    // Win is tested before the full-board draw so a winning
                    // ninth move is credited to the mover.
                    if (w_win) begin
                        r_state  <= S_DONE;
                        r_winner <= w_mover_code;
                    end else if (r_move_count == 4'd9) begin
                        r_state  <= S_DONE;
                        r_winner <= 2'b11;
                    end else begin
                        r_turn  <= ~r_turn;
                        r_state <= r_turn ? S_WAIT_P1 : S_WAIT_P2;
                        r_timer <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign p1_ready     = (r_state == S_WAIT_P1);
    assign p2_ready     = (r_state == S_WAIT_P2);
    assign board        = r_board;
    assign turn         = r_turn;
    assign move_count   = r_move_count;
    assign move_invalid = r_move_invalid;
    assign game_over    = (r_state == S_DONE);
    assign winner       = r_winner;
    assign timed_out    = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_game_controller
//  Description : Self-checking bench for game_controller. A move table with
//                hand-computed boards drives complete games; directed
//                sequences cover reset behaviour, ignored inputs and the turn
//                timeout on a second instance with TURN_TIMEOUT = 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default timeout)
    logic        rst_n, start, p1_valid, p2_valid;
    logic [1:0]  p1_row, p1_col, p2_row, p2_col;
    logic        p1_ready, p2_ready, turn, move_invalid, game_over, timed_out;
    logic [17:0] board;
    logic [3:0]  move_count;
    logic [1:0]  winner;

    // Timeout instance
    logic        t_start, t_p1_valid, t_p2_valid;
    logic [1:0]  t_p1_row, t_p1_col, t_p2_row, t_p2_col;
    logic        t_p1_ready, t_p2_ready, t_turn, t_move_invalid, t_game_over, t_timed_out;
    logic [17:0] t_board;
    logic [3:0]  t_move_count;
    logic [1:0]  t_winner;

    game_controller u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .p1_valid(p1_valid), .p1_row(p1_row), .p1_col(p1_col),
        .p2_valid(p2_valid), .p2_row(p2_row), .p2_col(p2_col),
        .p1_ready(p1_ready), .p2_ready(p2_ready), .board(board), .turn(turn),
        .move_count(move_count), .move_invalid(move_invalid),
        .game_over(game_over), .winner(winner), .timed_out(timed_out)
    );

    game_controller #(.TURN_TIMEOUT(8)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .start(t_start),
        .p1_valid(t_p1_valid), .p1_row(t_p1_row), .p1_col(t_p1_col),
        .p2_valid(t_p2_valid), .p2_row(t_p2_row), .p2_col(t_p2_col),
        .p1_ready(t_p1_ready), .p2_ready(t_p2_ready), .board(t_board), .turn(t_turn),
        .move_count(t_move_count), .move_invalid(t_move_invalid),
        .game_over(t_game_over), .winner(t_winner), .timed_out(t_timed_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          new_game;
        bit          pl;
        logic [1:0]  row;
        logic [1:0]  col;
        bit          inv;
        logic [17:0] board;
        bit          turn;
        logic [3:0]  cnt;
        bit          over;
        logic [1:0]  win;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit ng, input bit pl, input logic [1:0] r, input logic [1:0] c,
                       input bit inv, input logic [17:0] b, input bit t, input logic [3:0] n,
                       input bit ov, input logic [1:0] w);
        vec_t v;
        v.new_game = ng; v.pl = pl; v.row = r; v.col = c; v.inv = inv;
        v.board = b; v.turn = t; v.cnt = n; v.over = ov; v.win = w;
        vecs.push_back(v);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " board"},        32'(board), 32'h0);
        chk({tag, " turn"},         32'(turn), 32'h0);
        chk({tag, " move_count"},   32'(move_count), 32'h0);
        chk({tag, " move_invalid"}, 32'(move_invalid), 32'h0);
        chk({tag, " game_over"},    32'(game_over), 32'h0);
        chk({tag, " winner"},       32'(winner), 32'h0);
        chk({tag, " timed_out"},    32'(timed_out), 32'h0);
        chk({tag, " p1_ready"},     32'(p1_ready), 32'h0);
        chk({tag, " p2_ready"},     32'(p2_ready), 32'h0);
    endtask

    // Called #1 after an edge; leaves the main DUT in WAIT_P1.
    task automatic start_game(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " start board"}, 32'(board), 32'h0);
        chk({tag, " start turn"},  32'(turn), 32'h0);
        chk({tag, " start count"}, 32'(move_count), 32'h0);
        chk({tag, " start winner"}, 32'(winner), 32'h0);
        chk({tag, " start p1_ready"}, 32'(p1_ready), 32'h1);
    endtask

    task automatic drive(input bit pl, input logic [1:0] r, input logic [1:0] c);
        if (pl) begin p2_valid = 1'b1; p2_row = r; p2_col = c; end
        else    begin p1_valid = 1'b1; p1_row = r; p1_col = c; end
    endtask

    task automatic play(input bit pl, input logic [1:0] r, input logic [1:0] c);
        drive(pl, r, c);
        @(posedge clk); #1;
        p1_valid = 1'b0; p2_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
        p1_row = 2'd0; p1_col = 2'd0; p2_row = 2'd0; p2_col = 2'd0;
        t_start = 1'b0; t_p1_valid = 1'b0; t_p2_valid = 1'b0;
        t_p1_row = 2'd0; t_p1_col = 2'd0; t_p2_row = 2'd0; t_p2_col = 2'd0;

        // Game 1: P1 wins on the top row.
        add(1, 0, 2'd0, 2'd0, 0, 18'h00001, 1, 4'd1, 0, 2'b00);
        add(0, 1, 2'd1, 2'd0, 0, 18'h00081, 0, 4'd2, 0, 2'b00);
        add(0, 0, 2'd0, 2'd1, 0, 18'h00085, 1, 4'd3, 0, 2'b00);
        add(0, 1, 2'd1, 2'd1, 0, 18'h00285, 0, 4'd4, 0, 2'b00);
        add(0, 0, 2'd0, 2'd2, 0, 18'h00295, 0, 4'd5, 1, 2'b01);
        // Game 2: full-board draw (X O X / X O O / O X X).
        add(1, 0, 2'd0, 2'd0, 0, 18'h00001, 1, 4'd1, 0, 2'b00);
        add(0, 1, 2'd0, 2'd1, 0, 18'h00009, 0, 4'd2, 0, 2'b00);
        add(0, 0, 2'd0, 2'd2, 0, 18'h00019, 1, 4'd3, 0, 2'b00);
        add(0, 1, 2'd1, 2'd1, 0, 18'h00219, 0, 4'd4, 0, 2'b00);
        add(0, 0, 2'd1, 2'd0, 0, 18'h00259, 1, 4'd5, 0, 2'b00);
        add(0, 1, 2'd1, 2'd2, 0, 18'h00A59, 0, 4'd6, 0, 2'b00);
        add(0, 0, 2'd2, 2'd1, 0, 18'h04A59, 1, 4'd7, 0, 2'b00);
        add(0, 1, 2'd2, 2'd0, 0, 18'h06A59, 0, 4'd8, 0, 2'b00);
        add(0, 0, 2'd2, 2'd2, 0, 18'h16A59, 0, 4'd9, 1, 2'b11);
        // Game 3: occupied cell and off-board row are rejected.
        add(1, 0, 2'd1, 2'd1, 0, 18'h00100, 1, 4'd1, 0, 2'b00);
        add(0, 1, 2'd1, 2'd1, 1, 18'h00100, 1, 4'd1, 0, 2'b00);
        add(0, 1, 2'd3, 2'd0, 1, 18'h00100, 1, 4'd1, 0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Without start, a presented move goes nowhere.
        drive(0, 2'd0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle p1_ready", 32'(p1_ready), 32'h0);
        chk("idle board", 32'(board), 32'h0);
        chk("idle move_invalid", 32'(move_invalid), 32'h0);
        chk("idle count", 32'(move_count), 32'h0);
        p1_valid = 1'b0;

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            if (v.new_game) start_game($sformatf("v%0d", k));
            chk($sformatf("v%0d ready", k), 32'(v.pl ? p2_ready : p1_ready), 32'h1);
            drive(v.pl, v.row, v.col);
            @(posedge clk); #1;
            p1_valid = 1'b0; p2_valid = 1'b0;
            chk($sformatf("v%0d move_invalid", k), 32'(move_invalid), 32'(v.inv));
            chk($sformatf("v%0d board", k), 32'(board), 32'(v.board));
            chk($sformatf("v%0d count", k), 32'(move_count), 32'(v.cnt));
            chk($sformatf("v%0d early over", k), 32'(game_over), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("v%0d turn", k), 32'(turn), 32'(v.turn));
            chk($sformatf("v%0d game_over", k), 32'(game_over), 32'(v.over));
            chk($sformatf("v%0d winner", k), 32'(winner), 32'(v.win));
            chk($sformatf("v%0d pulse end", k), 32'(move_invalid), 32'h0);
            if (v.over) chk($sformatf("v%0d timed_out", k), 32'(timed_out), 32'h0);
        end

        // Still in WAIT_P2 after game 3: start must be ignored.
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign start p2_ready", 32'(p2_ready), 32'h1);
        chk("ign start turn", 32'(turn), 32'h1);
        chk("ign start board", 32'(board), 32'h00100);
        chk("ign start count", 32'(move_count), 32'h1);
        play(1, 2'd0, 2'd0);
        chk("p2 move board", 32'(board), 32'h00102);
        chk("p2 move p1_ready", 32'(p1_ready), 32'h1);
        // Player 2 presenting out of turn is ignored without a reject pulse.
        drive(1, 2'd2, 2'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("oot%0d move_invalid", i), 32'(move_invalid), 32'h0);
            chk($sformatf("oot%0d board", i), 32'(board), 32'h00102);
        end
        chk("oot p2_ready", 32'(p2_ready), 32'h0);
        p2_valid = 1'b0;

        // Reset asserted while the fourth move is being checked.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_game("g4");
        play(0, 2'd0, 2'd0);
        play(1, 2'd1, 2'd1);
        play(0, 2'd2, 2'd2);
        drive(1, 2'd0, 2'd2);
        @(posedge clk); #1;
        p2_valid = 1'b0;
        chk("g4 pre-reset count", 32'(move_count), 32'h4);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post reset p1_ready", 32'(p1_ready), 32'h0);
        start_game("g5");

        // Timeout instance: P1 idles for eight WAIT cycles.
        t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("to7 game_over", 32'(t_game_over), 32'h0);
        chk("to7 p1_ready", 32'(t_p1_ready), 32'h1);
        @(posedge clk); #1;
        chk("to8 game_over", 32'(t_game_over), 32'h1);
        chk("to8 winner", 32'(t_winner), 32'h2);
        chk("to8 timed_out", 32'(t_timed_out), 32'h1);
        chk("to8 p1_ready", 32'(t_p1_ready), 32'h0);

        // Legal move on the timeout edge wins; then P2 times out.
        t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        chk("to restart timed_out", 32'(t_timed_out), 32'h0);
        repeat (7) @(posedge clk);
        #1;
        t_p1_valid = 1'b1; t_p1_row = 2'd1; t_p1_col = 2'd1;
        @(posedge clk); #1;
        t_p1_valid = 1'b0;
        chk("tie game_over", 32'(t_game_over), 32'h0);
        chk("tie timed_out", 32'(t_timed_out), 32'h0);
        chk("tie board", 32'(t_board), 32'h00100);
        chk("tie count", 32'(t_move_count), 32'h1);
        @(posedge clk); #1;
        chk("tie p2_ready", 32'(t_p2_ready), 32'h1);
        chk("tie turn", 32'(t_turn), 32'h1);
        repeat (7) @(posedge clk);
        #1;
        chk("p2to7 game_over", 32'(t_game_over), 32'h0);
        @(posedge clk); #1;
        chk("p2to8 game_over", 32'(t_game_over), 32'h1);
        chk("p2to8 winner", 32'(t_winner), 32'h1);
        chk("p2to8 timed_out", 32'(t_timed_out), 32'h1);
        chk("p2to8 move_invalid", 32'(t_move_invalid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TURN_TIMEOUT, default 1000: max cycles a player may hold its turn; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  level; begins a new game when sampled high in IDLE or DONE.
REQ-005 p1_valid  input  1  player 1 presents a move.
REQ-006 p1_row, p1_col  input  2 each  player 1 move row and column; legal values 0-2.
REQ-007 p2_valid  input  1  player 2 presents a move.
REQ-008 p2_row, p2_col  input  2 each  player 2 move row and column; legal values 0-2.
REQ-009 p1_ready, p2_ready  output  1 each  controller accepts that player's move this cycle.
REQ-010 board  output  18  cell i = row*3+col in board[2i+1:2i]: 00 empty, 01 player 1, 10 player 2.
REQ-011 turn  output  1  0 = player 1 to move, 1 = player 2 to move.
REQ-012 move_count  output  4  number of accepted moves, 0-9.
REQ-013 move_invalid  output  1  one-cycle pulse on a rejected move.
REQ-014 game_over  output  1  high while in DONE.
REQ-015 winner  output  2  00 none, 01 player 1, 10 player 2, 11 draw; valid while game_over.
REQ-016 timed_out  output  1  high in DONE when the game ended by timeout.

Function
REQ-017 States SHALL be IDLE, WAIT_P1, WAIT_P2, CHECK and DONE.
REQ-018 Transitions: IDLE or DONE with start=1 -> clear board, move_count, winner, timed_out, turn=0 -> WAIT_P1.
REQ-019 start in WAIT_P1, WAIT_P2 or CHECK SHALL be ignored.
REQ-020 p1_ready = (state==WAIT_P1); p2_ready = (state==WAIT_P2); valid from the non-turn player is ignored, no pulse.
REQ-021 Handshake occurs on an edge where valid and ready are both high.
REQ-022 A handshake with row==3, col==3 or an occupied cell is rejected: move_invalid high for the next cycle, board and state unchanged, timeout counter not reset.
REQ-023 A legal handshake at edge E0 writes the cell and increments move_count at E0, and the state becomes CHECK.
REQ-024 CHECK lasts exactly one cycle; it evaluates all 8 lines (3 rows, 3 columns, 2 diagonals) for the mover's code only.
REQ-025 At edge E1, a win -> DONE, winner = mover.
REQ-026 At E1, no win and move_count==9 -> DONE, winner=11.
REQ-027 At E1, otherwise turn toggles and the state goes to the other player's WAIT; that player's ready is high in the cycle after E1.
REQ-028 A win on the 9th move SHALL report the player, not a draw.
REQ-029 Turn timer: reset to 0 on entry to a WAIT state, incremented each WAIT cycle without a legal handshake.
REQ-030 When the timer reaches TURN_TIMEOUT (nonzero): -> DONE, winner = opponent, timed_out=1.
REQ-031 A legal handshake on the same edge the timeout is reached takes priority over the timeout.
REQ-032 In DONE, board, winner and move_count SHALL hold until start.
REQ-033 move_invalid SHALL be registered; all other outputs derive from registered state only (no combinational path from p*_valid).

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, board=0, turn=0, move_count=0, move_invalid=0, game_over=0, winner=00, timed_out=0, timer=0, both readies low, including mid-game and in CHECK.
REQ-035 After rst_n deasserts, no move is accepted until start is sampled high.

Verification
REQ-036 Reset, start, then alternate moves P1(0,0), P2(1,0), P1(0,1), P2(1,1), P1(0,2) -> winner=01, game_over=1, move_count=5, board[5:0]=010101.
REQ-037 Nine alternating moves with no line filled -> winner=11, move_count=9, game_over one cycle after the 9th handshake.
REQ-038 P1(1,1), then P2(1,1), then P2(3,0) -> two move_invalid pulses, board unchanged, turn=1, p2_ready stays high.
REQ-039 TURN_TIMEOUT=8, start, P1 idle for 8 cycles -> winner=10, timed_out=1.
REQ-040 Assert rst_n low during CHECK after 4 moves -> all outputs at reset values; later start -> empty board, turn=0.
REQ-041 p2_valid held high during WAIT_P1 -> no acceptance and no move_invalid; start during WAIT_P2 -> ignored.
